pulse_tx_sequencer: RTL and testbench

- Sequences the transmit bit-selector datapath. It latches a PULSE_LENGTH-bit pulse pattern and drives a one-hot select vector, so the combinational selector emits the pattern serially, LSB first.
- Each bit is held for a programmable number of clock cycles. The whole pattern repeats a programmable number of passes.
- Sits between the transmit-control FSM, which provides the start/abort handshake, and the bit-select datapath, which receives pulse_q and select.

---
 rtl/pulse_tx_sequencer_if.sv | 28 ++
 rtl/pulse_tx_sequencer.sv | 126 ++++++++++++
 tb/tb_pulse_tx_sequencer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_tx_sequencer_if.sv
// Start/abort handshake and bit-select datapath bundle for pulse_tx_sequencer.
// Master: transmit control (start, abort, pattern, period, repeats); slave: sequencer.
interface pulse_tx_sequencer_if #(
  parameter int PULSE_LENGTH = 32,
  parameter int DIV_WIDTH    = 16,
  parameter int REP_WIDTH    = 8
);
  logic                    start;
  logic                    abort;
  logic [PULSE_LENGTH-1:0] pulse_in;
  logic [DIV_WIDTH-1:0]    bit_period;
  logic [REP_WIDTH-1:0]    repeat_count;
  logic [PULSE_LENGTH-1:0] pulse_q;
  logic [PULSE_LENGTH-1:0] select;
  logic                    busy;
  logic                    bit_strobe;
  logic                    done;

  modport master (
    output start, abort, pulse_in, bit_period, repeat_count,
    input  pulse_q, select, busy, bit_strobe, done
  );

  modport slave (
    input  start, abort, pulse_in, bit_period, repeat_count,
    output pulse_q, select, busy, bit_strobe, done
  );
endinterface

// File: rtl/pulse_tx_sequencer.sv
// Serialises a latched pulse pattern LSB first via a one-hot select vector.
// Ports: clk, rstb (async active-low), bus (slave: start/abort in, pulse_q/select/status out).
module pulse_tx_sequencer #(
  parameter int PULSE_LENGTH = 32,
  parameter int DIV_WIDTH    = 16,
  parameter int REP_WIDTH    = 8
) (
  input logic clk,
  input logic rstb,
  pulse_tx_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [PULSE_LENGTH-1:0] pulse_q, pulse_d;
  logic [PULSE_LENGTH-1:0] sel_q, sel_d;
  logic [DIV_WIDTH-1:0]    period_q, period_d;
  logic [DIV_WIDTH-1:0]    cyc_q, cyc_d;
  logic [REP_WIDTH-1:0]    pass_q, pass_d;
  logic                    busy_q, busy_d;
  logic                    strobe_q, strobe_d;
  logic                    done_q, done_d;
  logic                    bit_end;
  logic                    last_bit;

  assign bit_end  = (cyc_q == period_q - DIV_WIDTH'(1));
  assign last_bit = sel_q[PULSE_LENGTH-1];

  always_comb begin
    state_d  = state_q;
    pulse_d  = pulse_q;
    sel_d    = sel_q;
    period_d = period_q;
    cyc_d    = cyc_q;
    pass_d   = pass_q;
    busy_d   = busy_q;
    strobe_d = 1'b0;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d  = RUN;
          pulse_d  = bus.pulse_in;
          period_d = (bus.bit_period == '0) ?
                     DIV_WIDTH'(1) : bus.bit_period;
          pass_d   = bus.repeat_count;
          cyc_d    = '0;
          sel_d    = PULSE_LENGTH'(1);
          busy_d   = 1'b1;
          strobe_d = 1'b1;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          sel_d   = '0;
          busy_d  = 1'b0;
          cyc_d   = '0;
          pass_d  = '0;
        end else if (!bit_end) begin
          cyc_d = cyc_q + DIV_WIDTH'(1);
        end else begin
          cyc_d = '0;
          if (!last_bit) begin
            sel_d    = sel_q << 1;
            strobe_d = 1'b1;
          end else if (pass_q != '0) begin
            // Next pass starts straight away, no gap cycle.
            pass_d   = pass_q - REP_WIDTH'(1);
            sel_d    = PULSE_LENGTH'(1);
            strobe_d = 1'b1;
          end else begin
            state_d = FINISH;
            sel_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= IDLE;
      pulse_q  <= '0;
      sel_q    <= '0;
      period_q <= '0;
      cyc_q    <= '0;
      pass_q   <= '0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pulse_q  <= pulse_d;
      sel_q    <= sel_d;
      period_q <= period_d;
      cyc_q    <= cyc_d;
      pass_q   <= pass_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
      done_q   <= done_d;
    end
  end

  assign bus.pulse_q    = pulse_q;
  assign bus.select     = sel_q;
  assign bus.busy       = busy_q;
  assign bus.bit_strobe = strobe_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_pulse_tx_sequencer.sv
// Randomised self-checking bench for pulse_tx_sequencer.
// Expected outputs come from a per-cycle arithmetic model of the run.
module tb_pulse_tx_sequencer;

  localparam int PL = 32;

  logic clk;
  logic rstb;
  int   checks;
  int   failures;

  pulse_tx_sequencer_if #(.PULSE_LENGTH(PL)) bus ();

  pulse_tx_sequencer #(.PULSE_LENGTH(PL)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string nm);
    checks++;
    if (bus.select !== '0 || bus.busy !== 1'b0 ||
        bus.bit_strobe !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL %s: sel=%h busy=%b strb=%b done=%b required all 0",
               nm, bus.select, bus.busy, bus.bit_strobe, bus.done);
    end
  endtask

  // Drives one full transmission and compares every cycle against the model:
  // cycle t of N=(rep+1)*PL*p shows bit (t/p)%PL, strobe when t%p==0.
  task automatic run_check(input logic [PL-1:0] pat, input logic [15:0] per,
                           input logic [7:0] rep, input bit mid_start,
                           input string nm);
    int p;
    int n;
    int b;
    logic [PL-1:0] exp_sel;
    logic exp_strb;
    logic exp_dout;
    p = (per == 0) ? 1 : int'(per);
    n = (int'(rep) + 1) * PL * p;
    bus.pulse_in     = pat;
    bus.bit_period   = per;
    bus.repeat_count = rep;
    bus.start        = 1'b1;
    tick();
    bus.start        = 1'b0;
    bus.pulse_in     = $urandom;
    bus.bit_period   = 16'($urandom);
    bus.repeat_count = 8'($urandom);
    for (int t = 0; t < n; t++) begin
      b        = (t / p) % PL;
      exp_sel  = PL'(1) << b;
      exp_strb = (t % p) == 0;
      exp_dout = pat[b];
      checks++;
      if (bus.select !== exp_sel || bus.busy !== 1'b1 ||
          bus.bit_strobe !== exp_strb || bus.done !== 1'b0 ||
          bus.pulse_q !== pat ||
          (|(bus.pulse_q & bus.select)) !== exp_dout) begin
        failures++;
        $display("FAIL %s t=%0d: sel=%h busy=%b strb=%b done=%b pq=%h req sel=%h busy=1 strb=%b done=0 pq=%h dout=%b",
                 nm, t, bus.select, bus.busy, bus.bit_strobe, bus.done,
                 bus.pulse_q, exp_sel, exp_strb, pat, exp_dout);
      end
      if (mid_start && t == 5) begin
        bus.start    = 1'b1;
        bus.pulse_in = ~pat;
      end
      if (mid_start && t == 7) bus.start = 1'b0;
      tick();
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.select !== '0 ||
        bus.bit_strobe !== 1'b0) begin
      failures++;
      $display("FAIL %s done-cycle: done=%b busy=%b sel=%h strb=%b req done=1 busy=0 sel=0 strb=0",
               nm, bus.done, bus.busy, bus.select, bus.bit_strobe);
    end
    tick();
    check_idle({nm, " after-done"});
  endtask

  task automatic test_reset();
    rstb             = 1'b0;
    bus.start        = 1'($urandom);
    bus.abort        = 1'($urandom);
    bus.pulse_in     = $urandom;
    bus.bit_period   = 16'($urandom);
    bus.repeat_count = 8'($urandom);
    repeat (3) tick();
    checks++;
    if (bus.pulse_q !== '0 || bus.select !== '0 || bus.busy !== 1'b0 ||
        bus.bit_strobe !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset: pq=%h sel=%h busy=%b strb=%b done=%b required all 0",
               bus.pulse_q, bus.select, bus.busy, bus.bit_strobe, bus.done);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    @(negedge clk);
    rstb = 1'b1;
    tick();
    run_check(32'hA5A5_0001, 16'd1, 8'd0, 1'b0, "basic");
  endtask

  task automatic test_bit_period();
    run_check(32'h0000_0003, 16'd3, 8'd0, 1'b0, "period3");
  endtask

  task automatic test_period_zero_repeat();
    run_check($urandom, 16'd0, 8'd2, 1'b0, "period0_rep2");
  endtask

  task automatic test_random_runs();
    for (int i = 0; i < 6; i++)
      run_check($urandom, 16'($urandom_range(0, 4)),
                8'($urandom_range(0, 2)), 1'b0, "random");
  endtask

  task automatic test_abort();
    bit seen_done;
    bus.pulse_in     = $urandom;
    bus.bit_period   = 16'd2;
    bus.repeat_count = 8'd0;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int t = 0; t < 10; t++) tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.select !== (PL'(1) << 5)) begin
      failures++;
      $display("FAIL abort-pre: busy=%b sel=%h req busy=1 sel=%h",
               bus.busy, bus.select, PL'(1) << 5);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_idle("abort");
    seen_done = 1'b0;
    for (int t = 0; t < 80; t++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done = 1'b1;
      tick();
    end
    checks++;
    if (seen_done) begin
      failures++;
      $display("FAIL abort-quiet: activity=1 required 0");
    end
    bus.start = 1'b1;
    bus.abort = 1'b1;
    repeat (3) begin
      tick();
      check_idle("start+abort idle");
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    tick();
  endtask

  task automatic test_ignored_start();
    run_check($urandom, 16'd1, 8'd0, 1'b1, "ignored_start");
  endtask

  task automatic test_back_to_back();
    int guard;
    bus.pulse_in     = $urandom;
    bus.bit_period   = 16'd1;
    bus.repeat_count = 8'd0;
    bus.start        = 1'b1;
    guard = 0;
    tick();
    while (bus.done !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 200) begin
      failures++;
      $display("FAIL b2b-timeout: done=%b required 1 within 200 cycles",
               bus.done);
    end
    tick();
    check_idle("b2b gap");
    tick();
    checks++;
    if (bus.busy !== 1'b1 || bus.select !== PL'(1) ||
        bus.bit_strobe !== 1'b1) begin
      failures++;
      $display("FAIL b2b-restart: busy=%b sel=%h strb=%b req busy=1 sel=1 strb=1",
               bus.busy, bus.select, bus.bit_strobe);
    end
    bus.start = 1'b0;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    bus.pulse_in     = 32'hDEAD_BEEF;
    bus.bit_period   = 16'd1;
    bus.repeat_count = 8'd1;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int t = 0; t < 17; t++) tick();
    checks++;
    if (bus.select !== (PL'(1) << 17)) begin
      failures++;
      $display("FAIL async-pre: sel=%h req %h", bus.select, PL'(1) << 17);
    end
    #2;
    rstb = 1'b0;
    #1;
    checks++;
    if (bus.pulse_q !== '0 || bus.select !== '0 || bus.busy !== 1'b0 ||
        bus.bit_strobe !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL async-reset: pq=%h sel=%h busy=%b strb=%b done=%b required all 0",
               bus.pulse_q, bus.select, bus.busy, bus.bit_strobe, bus.done);
    end
    @(negedge clk);
    rstb = 1'b1;
    repeat (5) begin
      tick();
      check_idle("post-reset idle");
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_bit_period();
    test_period_zero_repeat();
    test_random_runs();
    test_abort();
    test_ignored_start();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
